// File: rtl/instr_fetch_unit_pkg.sv
// Shared CPU opcode/funct constants, fetch FSM state encoding and branch-target helper.
package cpu_defs_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } ifu_state_e;

  // PC-relative target: sign-extended word offset added to the link address.
  function automatic logic [31:0] branch_target(input logic [31:0] pc_plus4,
                                                input logic [15:0] imm);
    return pc_plus4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and the memory (slave).
interface instr_fetch_unit_if;

  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;

  modport master (output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_addr, output imem_rdata, output imem_valid);

endinterface

// File: rtl/instr_fetch_unit_next_pc_sel.sv
// Combinational next-PC selection applied when a branch/jump is resolved.
module next_pc_sel
  import cpu_defs_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        jump_i,
  input  logic        beq_i,
  input  logic        bne_i,
  input  logic        alu_zero_i,
  input  logic [31:0] rs_data_i,
  output logic [31:0] next_pc_o
);

  logic is_jr;
  logic take_branch;

  assign is_jr       = (instr_i[31:26] == OP_RTYPE) && (instr_i[5:0] == FUNCT_JR);
  assign take_branch = (beq_i && alu_zero_i) || (bne_i && !alu_zero_i);

  always_comb begin
    next_pc_o = pc_i;
    if (jump_i && is_jr) begin
      next_pc_o = rs_data_i;
    end else if (jump_i) begin
      next_pc_o = {pc_plus4_i[31:28], instr_i[25:0], 2'b00};
    end else if (take_branch) begin
      next_pc_o = branch_target(pc_plus4_i, instr_i[15:0]);
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC, instruction register and fetch FSM.
// Build macro IFU_WAIT_EN enables the imem_valid handshake and the WAIT state.
module instr_fetch_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ir_we,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        jump,
  input  logic        beq,
  input  logic        bne,
  input  logic        branch_eval,
  input  logic        alu_zero,
  input  logic [31:0] rs_data,
  output logic [31:0] imem_addr,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_cur,
  output logic [31:0] pc_plus4,
  output logic        fetch_busy,
  output logic        fetch_done,
  output logic        proto_err
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic [31:0] pc_cur_q;
  logic        done_q;
  logic        err_q;
  logic [31:0] redirect_pc;

  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign opcode     = instr_q[31:26];
  assign funct      = instr_q[5:0];
  assign pc_cur     = pc_cur_q;
  assign pc_plus4   = pc_cur_q + 32'd4;
  assign fetch_done = done_q;
  assign proto_err  = err_q;

  next_pc_sel u_next_pc_sel (
    .pc_i       (pc_q),
    .instr_i    (instr_q),
    .pc_plus4_i (pc_plus4),
    .jump_i     (jump),
    .beq_i      (beq),
    .bne_i      (bne),
    .alu_zero_i (alu_zero),
    .rs_data_i  (rs_data),
    .next_pc_o  (redirect_pc)
  );

`ifdef IFU_WAIT_EN
  logic busy_q;
  assign fetch_busy = busy_q;
`else
  logic unused_imem_valid;
  assign unused_imem_valid = imem_valid;
  assign fetch_busy        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= RESET_PC;
      pc_cur_q <= RESET_PC;
      instr_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef IFU_WAIT_EN
      busy_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A redirect wins over a coincident fetch request; the fetch is dropped.
          if (branch_eval) begin
            pc_q <= redirect_pc;
            if (ir_we) err_q <= 1'b1;
          end else if (ir_we) begin
`ifdef IFU_WAIT_EN
            if (imem_valid) begin
              instr_q  <= imem_rdata;
              pc_cur_q <= pc_q;
              pc_q     <= pc_q + 32'd4;
              done_q   <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              busy_q  <= 1'b1;
            end
`else
            instr_q  <= imem_rdata;
            pc_cur_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            done_q   <= 1'b1;
`endif
          end
        end
`ifdef IFU_WAIT_EN
        S_WAIT: begin
          if (ir_we || branch_eval) err_q <= 1'b1;
          if (imem_valid) begin
            instr_q  <= imem_rdata;
            pc_cur_q <= pc_q;
            pc_q     <= pc_q + 32'd4;
            done_q   <= 1'b1;
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected state is queued with each stimulus step
// and compared one cycle later. Honours IFU_WAIT_EN for the handshake scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ir_we, jump, beq, bne, branch_eval, alu_zero;
  logic [31:0] rs_data;
  logic [31:0] instr, pc_cur, pc_plus4;
  logic [5:0]  opcode, funct;
  logic        fetch_busy, fetch_done, proto_err;

  instr_fetch_unit_if bus ();

  always #5 clk = ~clk;

  instr_fetch_unit #(.RESET_PC(32'h100)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ir_we       (ir_we),
    .imem_rdata  (bus.imem_rdata),
    .imem_valid  (bus.imem_valid),
    .jump        (jump),
    .beq         (beq),
    .bne         (bne),
    .branch_eval (branch_eval),
    .alu_zero    (alu_zero),
    .rs_data     (rs_data),
    .imem_addr   (bus.imem_addr),
    .instr       (instr),
    .opcode      (opcode),
    .funct       (funct),
    .pc_cur      (pc_cur),
    .pc_plus4    (pc_plus4),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done),
    .proto_err   (proto_err)
  );

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cur;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                      input logic [31:0] cur, input logic busy, input logic done,
                      input logic err);
    exp_t e;
    e.tag = tag; e.pc = pc; e.instr = ins; e.cur = cur;
    e.busy = busy; e.done = done; e.err = err;
    sb.push_back(e);
  endtask

  task automatic quiet();
    ir_we = 1'b0; jump = 1'b0; beq = 1'b0; bne = 1'b0;
    branch_eval = 1'b0; alu_zero = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".pc"},     bus.imem_addr, e.pc);
      chk({e.tag, ".instr"},  instr, e.instr);
      chk({e.tag, ".opcode"}, {26'd0, opcode}, {26'd0, e.instr[31:26]});
      chk({e.tag, ".funct"},  {26'd0, funct},  {26'd0, e.instr[5:0]});
      chk({e.tag, ".pc_cur"}, pc_cur, e.cur);
      chk({e.tag, ".pc4"},    pc_plus4, e.cur + 32'd4);
      chk({e.tag, ".busy"},   {31'd0, fetch_busy}, {31'd0, e.busy});
      chk({e.tag, ".done"},   {31'd0, fetch_done}, {31'd0, e.done});
      chk({e.tag, ".err"},    {31'd0, proto_err},  {31'd0, e.err});
    end
    quiet();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    quiet();
    rs_data = '0;
    rst_n = 1'b0;
    bus.imem_rdata = '0;
    bus.imem_valid = 1'b1;
    #2;

    push("reset", 32'h100, 32'h0, 32'h100, 0, 0, 0); step();
    rst_n = 1'b1;

    ir_we = 1; bus.imem_rdata = 32'h2008_0005;
    push("fetch", 32'h104, 32'h2008_0005, 32'h100, 0, 1, 0); step();
    push("fetch_hold", 32'h104, 32'h2008_0005, 32'h100, 0, 0, 0); step();

    ir_we = 1; bus.imem_rdata = 32'h0800_0080;
    push("fetch_j", 32'h108, 32'h0800_0080, 32'h104, 0, 1, 0); step();
    branch_eval = 1; jump = 1;
    push("j_to_200", 32'h200, 32'h0800_0080, 32'h104, 0, 0, 0); step();

    ir_we = 1; bus.imem_rdata = 32'h1000_FFFE;
    push("fetch_beq", 32'h204, 32'h1000_FFFE, 32'h200, 0, 1, 0); step();
    branch_eval = 1; beq = 1; alu_zero = 0;
    push("beq_nt", 32'h204, 32'h1000_FFFE, 32'h200, 0, 0, 0); step();
    branch_eval = 1; bne = 1; alu_zero = 1;
    push("bne_nt", 32'h204, 32'h1000_FFFE, 32'h200, 0, 0, 0); step();
    branch_eval = 1; beq = 1; alu_zero = 1;
    push("beq_tk", 32'h1FC, 32'h1000_FFFE, 32'h200, 0, 0, 0); step();

    ir_we = 1; bus.imem_rdata = 32'h03E0_0008;
    push("fetch_jr", 32'h200, 32'h03E0_0008, 32'h1FC, 0, 1, 0); step();
    branch_eval = 1; jump = 1; rs_data = 32'h0000_0ABC;
    push("jr_abc", 32'h0000_0ABC, 32'h03E0_0008, 32'h1FC, 0, 0, 0); step();
    branch_eval = 1; jump = 1; rs_data = 32'h1000_0000;
    push("jr_hi", 32'h1000_0000, 32'h03E0_0008, 32'h1FC, 0, 0, 0); step();

    ir_we = 1; bus.imem_rdata = 32'h0800_0040;
    push("fetch_j2", 32'h1000_0004, 32'h0800_0040, 32'h1000_0000, 0, 1, 0); step();
    branch_eval = 1; jump = 1;
    push("j_region", 32'h1000_0100, 32'h0800_0040, 32'h1000_0000, 0, 0, 0); step();

    ir_we = 1; branch_eval = 1; beq = 1; alu_zero = 0; bus.imem_rdata = 32'hDEAD_BEEF;
    push("coincide", 32'h1000_0100, 32'h0800_0040, 32'h1000_0000, 0, 0, 1); step();

    ir_we = 1; bus.imem_rdata = 32'h03E0_0008;
    push("fetch_jr2", 32'h1000_0104, 32'h03E0_0008, 32'h1000_0100, 0, 1, 1); step();
    branch_eval = 1; jump = 1; rs_data = 32'hFFFF_FFFC;
    push("jr_top", 32'hFFFF_FFFC, 32'h03E0_0008, 32'h1000_0100, 0, 0, 1); step();
    ir_we = 1; bus.imem_rdata = 32'h1234_5678;
    push("wrap", 32'h0, 32'h1234_5678, 32'hFFFF_FFFC, 0, 1, 1); step();

    rst_n = 1'b0;
    push("reset2", 32'h100, 32'h0, 32'h100, 0, 0, 0); step();
    rst_n = 1'b1;

`ifdef IFU_WAIT_EN
    bus.imem_valid = 0; ir_we = 1; bus.imem_rdata = 32'hAAAA_0001;
    push("wait1", 32'h100, 32'h0, 32'h100, 1, 0, 0); step();
    push("wait2", 32'h100, 32'h0, 32'h100, 1, 0, 0); step();
    branch_eval = 1; jump = 1; rs_data = 32'h0000_0500;
    push("wait_br", 32'h100, 32'h0, 32'h100, 1, 0, 1); step();
    bus.imem_valid = 1;
    push("wait_cap", 32'h104, 32'hAAAA_0001, 32'h100, 0, 1, 1); step();
    push("wait_idle", 32'h104, 32'hAAAA_0001, 32'h100, 0, 0, 1); step();

    rst_n = 1'b0;
    push("reset3", 32'h100, 32'h0, 32'h100, 0, 0, 0); step();
    rst_n = 1'b1;
    bus.imem_valid = 0; ir_we = 1; bus.imem_rdata = 32'h5555_0002;
    push("wait_b1", 32'h100, 32'h0, 32'h100, 1, 0, 0); step();
    ir_we = 1;
    push("wait_irwe", 32'h100, 32'h0, 32'h100, 1, 0, 1); step();
    rst_n = 1'b0; bus.imem_valid = 1;
    push("mid_reset", 32'h100, 32'h0, 32'h100, 0, 0, 0); step();
    rst_n = 1'b1;
    push("post_reset", 32'h100, 32'h0, 32'h100, 0, 0, 0); step();
`else
    bus.imem_valid = 0; ir_we = 1; bus.imem_rdata = 32'hAAAA_0001;
    push("novalid_fetch", 32'h104, 32'hAAAA_0001, 32'h100, 0, 1, 0); step();
    push("novalid_idle", 32'h104, 32'hAAAA_0001, 32'h100, 0, 0, 0); step();
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded at reset.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- ir_we  in  1  fetch request pulse from the control FSM (instrReg).
- imem_rdata  in  32  instruction memory read data.
- imem_valid  in  1  imem_rdata valid; used only with IFU_WAIT_EN.
- jump  in  1  redirect to jump target.
- beq  in  1  branch-on-equal flag.
- bne  in  1  branch-on-not-equal flag.
- branch_eval  in  1  one-cycle pulse: resolve branch/jump now (FSM EX).
- alu_zero  in  1  ALU zero flag.
- rs_data  in  32  register rs value (JR target).
- imem_addr  out  32  instruction memory address (= pc).
- instr  out  32  instruction register.
- opcode  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- pc_cur  out  32  address of the instruction held in instr.
- pc_plus4  out  32  pc_cur + 4; JAL link value.
- fetch_busy  out  1  fetch in progress.
- fetch_done  out  1  one-cycle pulse on the cycle instr updates.
- proto_err  out  1  sticky protocol-violation flag.

Function
REQ-003 SHALL hold pc (next fetch address), instr, pc_cur and a 2-state FSM: IDLE, WAIT.
REQ-004 SHALL capture instr <= imem_rdata, pc_cur <= pc and pc <= pc + 4 on fetch completion, and pulse fetch_done high for exactly one cycle.
REQ-005 SHALL, without IFU_WAIT_EN, complete the fetch on the edge where ir_we = 1 in IDLE: latency 1 cycle, and the FSM never leaves IDLE.
REQ-006 SHALL, with IFU_WAIT_EN and ir_we = 1 in IDLE, complete in the same edge if imem_valid = 1; otherwise go to WAIT with fetch_busy = 1 and complete on the first edge with imem_valid = 1, then return to IDLE.
REQ-007 SHALL ignore ir_we while in WAIT and set proto_err.
REQ-008 SHALL, on a branch_eval edge in IDLE, load pc using the first matching rule:
- (a) jump and opcode = 0 and funct = 6'h08: rs_data.
- (b) jump: {pc_plus4[31:28], instr[25:0], 2'b00}.
- (c) (beq and alu_zero) or (bne and not alu_zero): pc_plus4 + (sign-extended instr[15:0] << 2).
- (d) otherwise: pc unchanged.
REQ-009 SHALL, on branch_eval in WAIT, ignore the redirect and set proto_err.
REQ-010 SHALL, if ir_we and branch_eval coincide in IDLE, perform the redirect only and set proto_err; no fetch starts.
REQ-011 SHALL wrap all PC arithmetic modulo 2^32 with no overflow indication; 32'hFFFF_FFFC + 4 = 0.
REQ-012 SHALL drive opcode, funct and imem_addr combinationally from instr and pc.

Reset
REQ-013 SHALL, when rst_n = 0 at posedge, set pc = RESET_PC, pc_cur = RESET_PC, instr = 0, FSM = IDLE, and fetch_busy = fetch_done = proto_err = 0; this applies in any state, including mid-WAIT.
REQ-014 SHALL give reset priority over ir_we, imem_valid and branch_eval.

Configuration
REQ-015 SHALL support macro IFU_WAIT_EN:
- Defined: imem_valid handshake and WAIT state compiled in.
- Undefined: imem_valid unused, no WAIT logic, fetch_busy tied 0.

Structure
REQ-016 SHALL take opcode/funct constants (J, JAL, JR, BEQ, BNE, Rtype) and the IDLE/WAIT state encoding from shared package cpu_defs_pkg.
REQ-017 SHALL place next-PC selection (REQ-008) in sub-module next_pc_sel, purely combinational.

Verification
REQ-018 Reset: rst_n = 0 for one edge with RESET_PC = 32'h100 -> pc = 32'h100, instr = 0, opcode = 0, proto_err = 0.
REQ-019 Fetch: ir_we pulse, imem_rdata = 32'h2008_0005 -> next cycle instr = 32'h2008_0005, opcode = 6'h08, pc_cur = 32'h100, pc = 32'h104, fetch_done pulses once.
REQ-020 Branch: instr = BEQ with imm 16'hFFFE, pc_cur = 32'h200, branch_eval with beq = 1, alu_zero = 1 -> pc = 32'h1FC; same with alu_zero = 0 -> pc = 32'h204.
REQ-021 Jumps: J with instr[25:0] = 26'h40, pc_plus4 = 32'h1000_0004 -> pc = 32'h1000_0100; JR (opcode 0, funct 08) with rs_data = 32'h0000_0ABC -> pc = 32'h0000_0ABC.
REQ-022 Wait (IFU_WAIT_EN): ir_we with imem_valid low for 3 cycles -> fetch_busy = 1 for 3 cycles, instr unchanged; imem_valid high -> capture, then IDLE. branch_eval during WAIT -> proto_err = 1, pc unchanged.
REQ-023 Mid-WAIT reset and wrap: rst_n low during WAIT -> IDLE, busy = 0. Fetch at pc = 32'hFFFF_FFFC -> pc = 0.
